// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types: data-memory op encoding, lane enables, access FSM states
package rv32i_types;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } dmem_op_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    function automatic logic is_store(input dmem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - replicates store data into byte lanes, builds byte-enable, flags misaligned accesses
module store_align
    import rv32i_types::*;
(
    input  dmem_op_t    mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [31:0] wdata,
    output logic [3:0]  byte_enable,
    output logic        misaligned
);

    // Loads always fetch the whole word; writeback extracts the byte/half.
    always_comb begin
        wdata       = 32'h0;
        byte_enable = BE_WORD;
        misaligned  = 1'b0;
        case (mem_op)
            MEM_LH, MEM_LHU: misaligned = offset[0];
            MEM_LW:          misaligned = |offset;
            MEM_SB: begin
                byte_enable = BE_BYTE0 << offset;
                wdata       = {4{store_data[7:0]}};
            end
            MEM_SH: begin
                byte_enable = offset[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata       = {2{store_data[15:0]}};
                misaligned  = offset[0];
            end
            MEM_SW: begin
                wdata      = store_data;
                misaligned = |offset;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - MEM-stage data-memory front end: holds a cache request until resp, stalls meanwhile
module dmem_access_unit
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  dmem_op_t          mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [ADDR_W-1:0] data_mem_address,
    output logic              data_mem_read,
    output logic              data_mem_write,
    output logic [DATA_W-1:0] data_mem_wdata,
    output logic [3:0]        data_mem_byte_enable,
    input  logic              data_mem_resp,
    input  logic [DATA_W-1:0] data_mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              misaligned
);

    dmem_state_t state, state_next;
    logic        accept, reject;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic        al_misaligned;

    store_align u_store_align (
        .mem_op      (mem_op),
        .offset      (addr[1:0]),
        .store_data  (store_data),
        .wdata       (al_wdata),
        .byte_enable (al_be),
        .misaligned  (al_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Stall is raised combinationally in the accept cycle so EX/MEM holds before the request leaves.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && (mem_op != MEM_NONE)) begin
                    if (al_misaligned) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (data_mem_resp) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_mem_address     <= '0;
            data_mem_read        <= 1'b0;
            data_mem_write       <= 1'b0;
            data_mem_wdata       <= '0;
            data_mem_byte_enable <= 4'b0000;
            load_data            <= '0;
            misaligned           <= 1'b0;
        end else begin
            misaligned <= reject;
            if (accept) begin
                data_mem_address     <= {addr[ADDR_W-1:2], 2'b00};
                data_mem_wdata       <= al_wdata;
                data_mem_byte_enable <= al_be;
                data_mem_read        <= !is_store(mem_op);
                data_mem_write       <= is_store(mem_op);
            end else if ((state == ST_BUSY) && data_mem_resp) begin
                data_mem_read  <= 1'b0;
                data_mem_write <= 1'b0;
                if (data_mem_read) load_data <= data_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - directed self-checking bench for dmem_access_unit
module tb_dmem_access_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    dmem_op_t    mem_op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] data_mem_address;
    logic        data_mem_read;
    logic        data_mem_write;
    logic [31:0] data_mem_wdata;
    logic [3:0]  data_mem_byte_enable;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;

    int tests_run = 0;
    int tests_failed = 0;

    int          r_wr, r_rd, r_stall, r_mis, r_req0;
    logic        r_done, r_done_stall;
    logic [31:0] r_addr, r_wdata, r_load;
    logic [3:0]  r_be;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .mem_op               (mem_op),
        .addr                 (addr),
        .store_data           (store_data),
        .data_mem_address     (data_mem_address),
        .data_mem_read        (data_mem_read),
        .data_mem_write       (data_mem_write),
        .data_mem_wdata       (data_mem_wdata),
        .data_mem_byte_enable (data_mem_byte_enable),
        .data_mem_resp        (data_mem_resp),
        .data_mem_rdata       (data_mem_rdata),
        .stall                (stall),
        .load_data            (load_data),
        .done                 (done),
        .misaligned           (misaligned)
    );

    // Presents one request at posedge+1, answers with resp n cycles later; records what the cache port saw.
    task automatic do_access(input dmem_op_t op, input logic [31:0] a, input logic [31:0] sd,
                             input int n, input logic [31:0] rd);
        r_wr = 0; r_rd = 0; r_stall = 0; r_mis = 0; r_req0 = 0;
        r_done = 1'b0; r_done_stall = 1'b0;
        r_addr = 32'h0; r_wdata = 32'h0; r_load = 32'h0; r_be = 4'h0;
        req_valid = 1'b1; mem_op = op; addr = a; store_data = sd;
        for (int cyc = 0; cyc <= n + 3; cyc++) begin
            data_mem_resp  = (cyc == n);
            data_mem_rdata = (cyc == n) ? rd : 32'h0BAD_0BAD;
            #1;
            if (cyc == 0) r_req0 = int'(data_mem_read | data_mem_write);
            if (stall) r_stall++;
            if (data_mem_write) r_wr++;
            if (data_mem_read) r_rd++;
            if ((data_mem_read || data_mem_write) && (r_wr + r_rd == 1)) begin
                r_addr = data_mem_address; r_wdata = data_mem_wdata; r_be = data_mem_byte_enable;
            end
            if (misaligned) r_mis++;
            if (done) begin
                r_done = 1'b1; r_load = load_data; r_done_stall = stall;
            end
            @(posedge clk); #1;
            req_valid = 1'b0; mem_op = MEM_LW; addr = 32'hFFFF_FFFF; store_data = $urandom;
            if (r_done) break;
        end
        mem_op = MEM_NONE; data_mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; mem_op = MEM_NONE; addr = 32'h0; store_data = 32'h0;
        data_mem_resp = 1'b0; data_mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if ({data_mem_read, data_mem_write, stall, done, misaligned} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_ctrl got %b want 00000", {data_mem_read, data_mem_write, stall, done, misaligned});
        end
        tests_run++;
        if ({data_mem_address, data_mem_wdata, data_mem_byte_enable, load_data} !== 100'h0) begin
            tests_failed++; $display("FAIL reset_data got addr=%h wdata=%h be=%b load=%h want all 0",
                                     data_mem_address, data_mem_wdata, data_mem_byte_enable, load_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_byte();
        do_access(MEM_SB, 32'h0000_1003, 32'hAABB_CC5D, 2, 32'h0);
        tests_run++;
        if (r_wr !== 2 || r_rd !== 0) begin
            tests_failed++; $display("FAIL sb_req_cycles got wr=%0d rd=%0d want wr=2 rd=0", r_wr, r_rd);
        end
        tests_run++;
        if (r_stall !== 3) begin
            tests_failed++; $display("FAIL sb_stall got %0d want 3", r_stall);
        end
        tests_run++;
        if (r_addr !== 32'h0000_1000 || r_be !== 4'b1000 || r_wdata !== 32'h5D5D_5D5D) begin
            tests_failed++; $display("FAIL sb_lanes got addr=%h be=%b wdata=%h want 00001000 1000 5d5d5d5d", r_addr, r_be, r_wdata);
        end
        tests_run++;
        if (r_done !== 1'b1 || r_done_stall !== 1'b0) begin
            tests_failed++; $display("FAIL sb_done got done=%b stall=%b want 1 0", r_done, r_done_stall);
        end
        #1;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL sb_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_store_half();
        do_access(MEM_SH, 32'h0000_2002, 32'h1234_BEEF, 1, 32'h0);
        tests_run++;
        if (r_addr !== 32'h0000_2000 || r_be !== 4'b1100 || r_wdata !== 32'hBEEF_BEEF) begin
            tests_failed++; $display("FAIL sh_lanes got addr=%h be=%b wdata=%h want 00002000 1100 beefbeef", r_addr, r_be, r_wdata);
        end
        tests_run++;
        if (r_wr !== 1 || r_done !== 1'b1) begin
            tests_failed++; $display("FAIL sh_done got wr=%0d done=%b want 1 1", r_wr, r_done);
        end
    endtask

    task automatic test_load_word();
        do_access(MEM_LW, 32'h0000_3000, 32'h0, 1, 32'hDEAD_BEEF);
        tests_run++;
        if (r_rd !== 1 || r_wr !== 0) begin
            tests_failed++; $display("FAIL lw_req_cycles got rd=%0d wr=%0d want 1 0", r_rd, r_wr);
        end
        tests_run++;
        if (r_addr !== 32'h0000_3000 || r_be !== 4'b1111 || r_wdata !== 32'h0) begin
            tests_failed++; $display("FAIL lw_req got addr=%h be=%b wdata=%h want 00003000 1111 0", r_addr, r_be, r_wdata);
        end
        tests_run++;
        if (r_done !== 1'b1 || r_load !== 32'hDEAD_BEEF || r_done_stall !== 1'b0) begin
            tests_failed++; $display("FAIL lw_result got done=%b load=%h stall=%b want 1 deadbeef 0", r_done, r_load, r_done_stall);
        end
    endtask

    task automatic test_misaligned();
        do_access(MEM_SW, 32'h0000_4001, 32'h5555_AAAA, 1, 32'h7777_7777);
        tests_run++;
        if (r_wr !== 0 || r_rd !== 0 || r_stall !== 0) begin
            tests_failed++; $display("FAIL sw_mis_noaccess got wr=%0d rd=%0d stall=%0d want 0 0 0", r_wr, r_rd, r_stall);
        end
        tests_run++;
        if (r_mis !== 1 || r_done !== 1'b0) begin
            tests_failed++; $display("FAIL sw_mis_pulse got mis=%0d done=%b want 1 0", r_mis, r_done);
        end
        do_access(MEM_LB, 32'h0000_4001, 32'h0, 1, 32'h1122_3344);
        tests_run++;
        if (r_rd !== 1 || r_be !== 4'b1111 || r_addr !== 32'h0000_4000 || r_mis !== 0) begin
            tests_failed++; $display("FAIL lb_after_mis got rd=%0d be=%b addr=%h mis=%0d want 1 1111 00004000 0", r_rd, r_be, r_addr, r_mis);
        end
        tests_run++;
        if (r_done !== 1'b1 || r_load !== 32'h1122_3344) begin
            tests_failed++; $display("FAIL lb_result got done=%b load=%h want 1 11223344", r_done, r_load);
        end
        do_access(MEM_LH, 32'h0000_4003, 32'h0, 1, 32'h0);
        tests_run++;
        if (r_mis !== 1 || r_rd !== 0) begin
            tests_failed++; $display("FAIL lh_mis got mis=%0d rd=%0d want 1 0", r_mis, r_rd);
        end
    endtask

    task automatic test_top_address();
        do_access(MEM_SW, 32'hFFFF_FFFC, 32'h0102_0304, 1, 32'h0);
        tests_run++;
        if (r_addr !== 32'hFFFF_FFFC || r_be !== 4'b1111 || r_wdata !== 32'h0102_0304 || r_wr !== 1) begin
            tests_failed++; $display("FAIL sw_top got addr=%h be=%b wdata=%h wr=%0d want fffffffc 1111 01020304 1",
                                     r_addr, r_be, r_wdata, r_wr);
        end
    endtask

    task automatic test_reset_in_busy();
        int done_cnt;
        done_cnt = 0;
        req_valid = 1'b1; mem_op = MEM_LH; addr = 32'h0000_5000; data_mem_resp = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++; $display("FAIL lh_accept_stall got %b want 1", stall);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; mem_op = MEM_NONE;
        #1;
        tests_run++;
        if (data_mem_read !== 1'b1) begin
            tests_failed++; $display("FAIL lh_busy_read got %b want 1", data_mem_read);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; data_mem_resp = 1'b1; data_mem_rdata = 32'hCAFE_F00D;
        #1;
        tests_run++;
        if (data_mem_read !== 1'b0 || stall !== 1'b0) begin
            tests_failed++; $display("FAIL rst_busy_drop got read=%b stall=%b want 0 0", data_mem_read, stall);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            data_mem_resp = 1'b0;
            #1;
            if (done) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0 || load_data !== 32'h0 || data_mem_read !== 1'b0) begin
            tests_failed++; $display("FAIL rst_late_resp got done_cnt=%0d load=%h read=%b want 0 0 0", done_cnt, load_data, data_mem_read);
        end
    endtask

    task automatic test_back_to_back();
        do_access(MEM_SW, 32'h0000_6000, 32'h600D_CAFE, 3, 32'h0);
        tests_run++;
        if (r_wr !== 3 || r_addr !== 32'h0000_6000 || r_done !== 1'b1 || r_req0 !== 0) begin
            tests_failed++; $display("FAIL b2b_sw got wr=%0d addr=%h done=%b req0=%0d want 3 00006000 1 0", r_wr, r_addr, r_done, r_req0);
        end
        do_access(MEM_LW, 32'h0000_6000, 32'h0, 3, 32'h600D_CAFE);
        tests_run++;
        if (r_req0 !== 0 || r_rd !== 3 || r_wr !== 0 || r_addr !== 32'h0000_6000) begin
            tests_failed++; $display("FAIL b2b_lw_req got req0=%0d rd=%0d wr=%0d addr=%h want 0 3 0 00006000", r_req0, r_rd, r_wr, r_addr);
        end
        tests_run++;
        if (r_done !== 1'b1 || r_load !== 32'h600D_CAFE || r_stall !== 4) begin
            tests_failed++; $display("FAIL b2b_lw_result got done=%b load=%h stall=%0d want 1 600dcafe 4", r_done, r_load, r_stall);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half();
        test_load_word();
        test_misaligned();
        test_top_address();
        test_reset_in_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
